// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The stall counter is built only when HAZARD_STALL_CNT_EN is defined.
package hazard_pkg;

    localparam int REG_W_DEF = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef logic [0:0] state_t;
    localparam state_t RUN        = 1'b0;
    localparam state_t LD_BR_WAIT = 1'b1;

endpackage

// File: rtl/hazard_reg_match.sv
// Flags when the ID instruction reads the register the EX instruction writes.
// $0 is hardwired to zero, so it never creates a dependency.
module hazard_reg_match
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    input  logic             uses_rt_i,
    input  logic [REG_W-1:0] dst_i,
    output logic             match_o
);

    logic dst_live;

    assign dst_live = (dst_i != REG_W'(REG_ZERO));
    assign match_o  = dst_live && ((rs_i == dst_i) || (uses_rt_i && (rt_i == dst_i)));

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use / branch-operand hazard controller: bubble insertion, PC/IF-ID holds, redirect.
// Define HAZARD_STALL_CNT_EN to add the saturating StallCount output.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
`ifdef HAZARD_STALL_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [REG_W-1:0] IFID_Rs,
    input  logic [REG_W-1:0] IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic             IFID_Branch,
    input  logic             IFID_Jump,
    input  logic             BranchTaken,
    input  logic             IDEX_MemRead,
    input  logic             IDEX_RegWrite,
    input  logic [REG_W-1:0] IDEX_Dst,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             CtrlZeroSel,
    output logic             PCSrcSel,
    output logic             IFIDFlush
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] StallCount
`endif
);

    state_t state_q, state_d;
    logic   match, load_use, br_dep, stall, redirect;

    hazard_reg_match #(.REG_W(REG_W)) u_match (
        .rs_i      (IFID_Rs),
        .rt_i      (IFID_Rt),
        .uses_rt_i (IFID_UsesRt),
        .dst_i     (IDEX_Dst),
        .match_o   (match)
    );

    assign load_use = IDEX_MemRead && match;
    assign br_dep   = IFID_Branch && IDEX_RegWrite && !IDEX_MemRead && match;

    // LD_BR_WAIT stalls regardless of inputs; the branch is re-evaluated on release.
    assign stall    = (state_q == LD_BR_WAIT) || load_use || br_dep;
    assign redirect = !stall && (IFID_Jump || (IFID_Branch && BranchTaken));

    always_comb begin
        state_d = RUN;
        if (state_q == RUN && load_use && IFID_Branch)
            state_d = LD_BR_WAIT;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Held reset forces pass-through so the pipeline drains cleanly.
    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        CtrlZeroSel = 1'b0;
        PCSrcSel    = 1'b0;
        IFIDFlush   = 1'b0;
        if (Rst_n) begin
            if (stall) begin
                PCWrite     = 1'b0;
                IFIDWrite   = 1'b0;
                CtrlZeroSel = 1'b1;
            end else if (redirect) begin
                PCSrcSel    = 1'b1;
                IFIDFlush   = 1'b1;
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (CtrlZeroSel && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign StallCount = cnt_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench: stimulus pushes hand-computed outputs, a negedge monitor pops and compares.
module tb_hazard_control_unit;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [4:0] IFID_Rs, IFID_Rt, IDEX_Dst;
    logic       IFID_UsesRt, IFID_Branch, IFID_Jump, BranchTaken;
    logic       IDEX_MemRead, IDEX_RegWrite;
    logic       PCWrite, IFIDWrite, CtrlZeroSel, PCSrcSel, IFIDFlush;
`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] StallCount;
`endif

    hazard_control_unit dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .IFID_Rs       (IFID_Rs),
        .IFID_Rt       (IFID_Rt),
        .IFID_UsesRt   (IFID_UsesRt),
        .IFID_Branch   (IFID_Branch),
        .IFID_Jump     (IFID_Jump),
        .BranchTaken   (BranchTaken),
        .IDEX_MemRead  (IDEX_MemRead),
        .IDEX_RegWrite (IDEX_RegWrite),
        .IDEX_Dst      (IDEX_Dst),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .CtrlZeroSel   (CtrlZeroSel),
        .PCSrcSel      (PCSrcSel),
        .IFIDFlush     (IFIDFlush)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .StallCount    (StallCount)
`endif
    );

    always #5 Clk = ~Clk;

    // {PCWrite, IFIDWrite, CtrlZeroSel, PCSrcSel, IFIDFlush}
    localparam logic [4:0] PASS  = 5'b11000;
    localparam logic [4:0] STALL = 5'b00100;
    localparam logic [4:0] REDIR = 5'b11011;

    typedef struct {
        int         id;
        logic [4:0] outs;
        int         cnt;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         errors  = 0;
    int         checks  = 0;
    int         run_cnt = 0;
    logic [4:0] act;

    assign act = {PCWrite, IFIDWrite, CtrlZeroSel, PCSrcSel, IFIDFlush};

    task automatic chk(input string nm, input int id, input logic [15:0] a, input logic [15:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s vec=%0d: got %0h expected %0h", nm, id, a, x);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic br, input logic jmp, input logic tk,
                         input logic mr, input logic rw, input logic [4:0] dst);
        IFID_Rs = rs; IFID_Rt = rt; IFID_UsesRt = uses;
        IFID_Branch = br; IFID_Jump = jmp; BranchTaken = tk;
        IDEX_MemRead = mr; IDEX_RegWrite = rw; IDEX_Dst = dst;
    endtask

    task automatic step(input int id, input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                        input logic br, input logic jmp, input logic tk,
                        input logic mr, input logic rw, input logic [4:0] dst,
                        input logic [4:0] x);
        @(posedge Clk);
        #1;
        drive(rs, rt, uses, br, jmp, tk, mr, rw, dst);
        sb.push_back('{id, x, run_cnt});
        if (x[2]) run_cnt++;
    endtask

    always @(negedge Clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("outs", e.id, 16'(act), 16'(e.outs));
`ifdef HAZARD_STALL_CNT_EN
            chk("stallcnt", e.id, StallCount, 16'(e.cnt));
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with a load-use + taken branch presented: pass-through only
        Rst_n = 1'b0;
        drive(5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8);
        #2;
        chk("rst_outs", 0, 16'(act), 16'(PASS));
`ifdef HAZARD_STALL_CNT_EN
        chk("rst_cnt", 0, StallCount, 16'd0);
`endif
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        //   id  rs     rt     use br jmp tk mr rw dst    expected
        step( 1, 5'd8,  5'd0,  0, 0, 0, 0, 1, 1, 5'd8,  STALL); // load-use
        step( 2, 5'd8,  5'd0,  0, 0, 0, 0, 0, 0, 5'd0,  PASS);  // bubble in EX
        step( 3, 5'd8,  5'd0,  0, 1, 0, 1, 1, 1, 5'd8,  STALL); // load -> branch
        step( 4, 5'd8,  5'd0,  0, 1, 0, 1, 1, 1, 5'd8,  STALL); // LD_BR_WAIT
        step( 5, 5'd8,  5'd0,  0, 1, 0, 1, 0, 0, 5'd0,  REDIR); // release, taken
        step( 6, 5'd1,  5'd9,  1, 1, 0, 0, 0, 1, 5'd9,  STALL); // ALU -> branch Rt
        step( 7, 5'd1,  5'd9,  1, 1, 0, 0, 0, 0, 5'd0,  PASS);
        step( 8, 5'd1,  5'd9,  1, 0, 0, 0, 0, 1, 5'd9,  PASS);  // ALU -> ALU forwards
        step( 9, 5'd0,  5'd0,  1, 0, 0, 0, 1, 1, 5'd0,  PASS);  // $0 never hazards
        step(10, 5'd3,  5'd9,  0, 0, 0, 0, 1, 1, 5'd9,  PASS);  // Rt unused
        step(11, 5'd1,  5'd2,  1, 1, 0, 1, 0, 1, 5'd5,  REDIR); // taken, no dep
        step(12, 5'd1,  5'd2,  0, 0, 1, 0, 0, 1, 5'd5,  REDIR); // jump
        step(13, 5'd4,  5'd0,  0, 0, 1, 0, 1, 1, 5'd4,  STALL); // jump held by load-use
        step(14, 5'd4,  5'd0,  0, 0, 0, 0, 1, 1, 5'd4,  STALL); // back-to-back
        step(15, 5'd7,  5'd0,  0, 1, 0, 0, 0, 1, 5'd7,  STALL); // ALU -> branch Rs
        step(16, 5'd7,  5'd0,  0, 0, 0, 0, 0, 1, 5'd7,  PASS);
        step(17, 5'd7,  5'd7,  1, 1, 0, 1, 0, 0, 5'd7,  REDIR); // no RegWrite: no dep
        step(18, 5'd8,  5'd0,  0, 1, 0, 0, 1, 1, 5'd8,  STALL); // enter LD_BR_WAIT
        step(19, 5'd0,  5'd0,  0, 0, 0, 0, 0, 0, 5'd0,  STALL); // Moore stall

        // Asynchronous reset pulse in the middle of LD_BR_WAIT
        @(negedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("async_rst_outs", 19, 16'(act), 16'(PASS));
`ifdef HAZARD_STALL_CNT_EN
        chk("async_rst_cnt", 19, StallCount, 16'd0);
`endif
        #1;
        Rst_n = 1'b1;
        run_cnt = 0;

        step(20, 5'd1,  5'd2,  0, 1, 0, 1, 0, 0, 5'd0,  REDIR); // RUN after reset
        step(21, 5'd0,  5'd0,  0, 0, 0, 0, 0, 0, 5'd0,  PASS);

        repeat (2) @(negedge Clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
